rptr_empty_ctrl: RTL

Read-side pointer and empty-flag controller for the asynchronous FIFO. It is the read-clock counterpart of the write-pointer/full logic.
- Holds the binary read address and the Gray read pointer that is exported to the write domain.
- Takes the write pointer already synchronised into the read domain.
- Produces a registered empty flag, a fill-level count, an almost-empty flag and a sticky underflow error.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/gray2bin_conv.sv | 14 +
 rtl/rptr_empty_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer types and Gray/binary helpers for the read and write controllers.
package fifo_pkg;

  localparam int unsigned DEF_ADDRSIZE = 4;

  typedef logic [DEF_ADDRSIZE:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  // XOR prefix from the MSB down, done in log2 doubling steps
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int unsigned s = 1; s <= DEF_ADDRSIZE; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter of parameterised width.
module gray2bin_conv #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin_c
);

  // Each binary bit is the XOR of all Gray bits at and above it
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin_c[i] = ^i_gray[W-1:i];
  end

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Async FIFO read-side controller: binary/Gray read pointers, registered empty,
// fill level, almost-empty and sticky underflow, all in the rclk domain.
module rptr_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE  = DEF_ADDRSIZE,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic                rclr_err,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rcount,
  output logic                runderflow
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_LIMIT = PW'(AE_THRESH);

  logic [ADDRSIZE:0] r_bin;
  logic [ADDRSIZE:0] r_ptr;
  logic [ADDRSIZE:0] r_count;
  logic              r_empty;
  logic              r_almost_empty;
  logic              r_underflow;

  logic              w_pop;
  logic              w_underflow;
  logic [ADDRSIZE:0] w_binnext;
  logic [ADDRSIZE:0] w_graynext;
  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_level;

  // Pop is gated by the registered empty so a read on empty never moves the pointer
  assign w_pop       = rinc & ~r_empty;
  assign w_underflow = rinc & r_empty;
  assign w_binnext   = r_bin + PW'(w_pop);
  assign w_graynext  = (w_binnext >> 1) ^ w_binnext;

  gray2bin_conv #(.W(PW)) u_wptr_g2b (
    .i_gray  (rq2_wptr),
    .o_bin_c (w_wbin)
  );

  // Modular difference handles pointer wrap; a full lap gives 2**ADDRSIZE
  assign w_level = w_wbin - w_binnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_bin          <= w_binnext;
      r_ptr          <= w_graynext;
      r_count        <= w_level;
      r_empty        <= (w_graynext == rq2_wptr);
      r_almost_empty <= (w_level <= AE_LIMIT);
      // New underflow takes priority over a same-cycle clear
      if (w_underflow) begin
        r_underflow <= 1'b1;
      end else if (rclr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign raddr         = r_bin[ADDRSIZE-1:0];
  assign rptr          = r_ptr;
  assign rempty        = r_empty;
  assign ralmost_empty = r_almost_empty;
  assign rcount        = r_count;
  assign runderflow    = r_underflow;

endmodule
